// File: rtl/alu_pkg.sv
// Opcode constants and FSM state type shared by the arbiter, its picker and the external ALU.
package alu_pkg;

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] XOR  = 4'd2;
  localparam logic [3:0] OR   = 4'd3;
  localparam logic [3:0] AND  = 4'd4;
  localparam logic [3:0] SLL  = 4'd5;
  localparam logic [3:0] SRL  = 4'd6;
  localparam logic [3:0] SRA  = 4'd7;
  localparam logic [3:0] SLT  = 4'd8;
  localparam logic [3:0] SLTU = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arb_pick.sv
// Two-way grant selection; round-robin when ALU_ARB_ROUND_ROBIN_EN is defined, else fixed priority to requester 0.
module alu_arb_pick
  import alu_pkg::*;
(
  input  logic [1:0] req_valid,
`ifdef ALU_ARB_ROUND_ROBIN_EN
  input  logic       last_grant,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (req_valid == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      grant = last_grant ? 2'b01 : 2'b10;
`else
      grant = 2'b01;
`endif
    end else begin
      grant = req_valid;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external ALU: grant, latch operands, execute one cycle, hold response.
// Build option: ALU_ARB_ROUND_ROBIN_EN selects round-robin contention (default fixed priority to requester 0).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req_op_0,
  input  logic [OP_W-1:0]   req_op_1,
  input  logic [DATA_W-1:0] req_a_0,
  input  logic [DATA_W-1:0] req_a_1,
  input  logic [DATA_W-1:0] req_b_0,
  input  logic [DATA_W-1:0] req_b_1,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [DATA_W-1:0] alu_in_1,
  output logic [DATA_W-1:0] alu_in_2,
  output logic [OP_W-1:0]   alu_operation,
  input  logic [DATA_W-1:0] alu_out
);

  state_e            state_q;
  logic              owner_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] result_q;
  logic              err_q;
  logic [1:0]        resp_valid_q;

  logic [1:0]        grant;
  logic              owner_d;
  logic [OP_W-1:0]   op_d;
  logic [DATA_W-1:0] a_d;
  logic [DATA_W-1:0] b_d;
  logic [DATA_W-1:0] result_d;
  logic              err_d;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic              last_grant_q;
`endif

  alu_arb_pick u_pick (
    .req_valid  (req_valid),
`ifdef ALU_ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_q),
`endif
    .grant      (grant)
  );

  // Combinational ready so the handshake completes in the same IDLE cycle; masked while reset is high.
  assign req_ready = (state_q == IDLE && !reset) ? grant : 2'b00;

  always_comb begin
    owner_d  = grant[1];
    op_d     = owner_d ? req_op_1 : req_op_0;
    a_d      = owner_d ? req_a_1  : req_a_0;
    b_d      = owner_d ? req_b_1  : req_b_0;
    err_d    = 32'(op_q) > 32'(SLTU);
    result_d = err_d ? '0 : alu_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_ready) begin
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            state_q <= EXEC;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_grant_q <= owner_d;
`endif
          end
        end
        EXEC: begin
          result_q     <= result_d;
          err_q        <= err_d;
          resp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready[owner_q]) begin
            resp_valid_q <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_in_1      = a_q;
  assign alu_in_2      = b_q;
  assign alu_operation = op_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = result_q;
  assign resp_err      = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural external ALU; expectations are hand-computed.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op_0, req_op_1;
  logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] alu_in_1, alu_in_2;
  logic [3:0]  alu_operation;
  logic [31:0] alu_out;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1),
    .req_b_0(req_b_0), .req_b_1(req_b_1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .alu_operation(alu_operation), .alu_out(alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model; unknown opcodes return a recognisable junk value.
  always_comb begin
    case (alu_operation)
      ADD:     alu_out = alu_in_1 + alu_in_2;
      SUB:     alu_out = alu_in_1 - alu_in_2;
      XOR:     alu_out = alu_in_1 ^ alu_in_2;
      OR:      alu_out = alu_in_1 | alu_in_2;
      AND:     alu_out = alu_in_1 & alu_in_2;
      SLL:     alu_out = alu_in_1 << alu_in_2[4:0];
      SRL:     alu_out = alu_in_1 >> alu_in_2[4:0];
      SRA:     alu_out = 32'($signed(alu_in_1) >>> alu_in_2[4:0]);
      SLT:     alu_out = {31'd0, $signed(alu_in_1) < $signed(alu_in_2)};
      SLTU:    alu_out = {31'd0, alu_in_1 < alu_in_2};
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 2'b01; resp_ready = 2'b00;
    req_op_0 = ADD; req_op_1 = ADD;
    req_a_0 = 32'd1; req_a_1 = 32'd2; req_b_0 = 32'd3; req_b_1 = 32'd4;
    #2;
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    tick(); tick();
    total++;
    if (resp_valid !== 2'b00 || resp_data !== 32'd0 || resp_err !== 1'b0) begin
      bad++; $display("FAIL reset_resp: got v=%b d=%h e=%b want 00/0/0", resp_valid, resp_data, resp_err);
    end
    total++;
    if (alu_in_1 !== 32'd0 || alu_in_2 !== 32'd0 || alu_operation !== 4'd0) begin
      bad++; $display("FAIL reset_alu: got %h %h %h want 0 0 0", alu_in_1, alu_in_2, alu_operation);
    end
    reset = 1'b0; req_valid = 2'b00;
    tick();
    total++;
    if (resp_valid !== 2'b00) begin bad++; $display("FAIL idle_no_req: got %b want 00", resp_valid); end
  endtask

  task automatic test_add();
    req_valid = 2'b01; req_op_0 = ADD; req_a_0 = 32'd5; req_b_0 = 32'd7;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL add_ready: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00; req_a_0 = 32'd99; req_op_0 = XOR;
    #1;
    total++;
    if (alu_operation !== ADD || alu_in_1 !== 32'd5 || alu_in_2 !== 32'd7) begin
      bad++; $display("FAIL add_exec: got op=%h a=%h b=%h want 0 5 7", alu_operation, alu_in_1, alu_in_2);
    end
    total++;
    if (resp_valid !== 2'b00) begin bad++; $display("FAIL add_early: got %b want 00", resp_valid); end
    tick();
    total++;
    if (resp_valid !== 2'b01 || resp_data !== 32'd12 || resp_err !== 1'b0) begin
      bad++; $display("FAIL add_resp: got v=%b d=%h e=%b want 01/c/0", resp_valid, resp_data, resp_err);
    end
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    total++;
    if (resp_valid !== 2'b00) begin bad++; $display("FAIL add_done: got %b want 00", resp_valid); end
  endtask

  task automatic test_contention();
    reset = 1'b1; tick(); reset = 1'b0;
    req_valid = 2'b11;
    req_op_0 = SUB; req_a_0 = 32'd10;   req_b_0 = 32'd3;
    req_op_1 = XOR; req_a_1 = 32'hF0;   req_b_1 = 32'hFF;
    resp_ready = 2'b00;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL cont_first: got %b want 01", req_ready); end
    tick(); tick();
    total++;
    if (resp_valid !== 2'b01 || resp_data !== 32'd7) begin
      bad++; $display("FAIL cont_resp0: got v=%b d=%h want 01/7", resp_valid, resp_data);
    end
    resp_ready = 2'b11;
    tick();
    total++;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    if (req_ready !== 2'b10) begin bad++; $display("FAIL cont_second: got %b want 10", req_ready); end
    tick(); tick();
    total++;
    if (resp_valid !== 2'b10 || resp_data !== 32'h0F) begin
      bad++; $display("FAIL cont_resp1: got v=%b d=%h want 10/f", resp_valid, resp_data);
    end
`else
    if (req_ready !== 2'b01) begin bad++; $display("FAIL cont_second: got %b want 01", req_ready); end
    tick(); tick();
    total++;
    if (resp_valid !== 2'b01 || resp_data !== 32'd7) begin
      bad++; $display("FAIL cont_resp1: got v=%b d=%h want 01/7", resp_valid, resp_data);
    end
`endif
    tick();
    req_valid = 2'b10;
    #1;
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL cont_single1: got %b want 10", req_ready); end
    tick(); req_valid = 2'b00; tick();
    total++;
    if (resp_valid !== 2'b10 || resp_data !== 32'h0F || resp_err !== 1'b0) begin
      bad++; $display("FAIL cont_req1: got v=%b d=%h e=%b want 10/f/0", resp_valid, resp_data, resp_err);
    end
    tick();
    resp_ready = 2'b00;
  endtask

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  task automatic test_opcodes();
    vec_t v[8];
    v[0] = '{1'b0, SRA,   32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0};
    v[1] = '{1'b1, SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0};
    v[2] = '{1'b0, SLTU,  32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0};
    v[3] = '{1'b1, 4'd12, 32'd3,         32'd4,         32'd0,         1'b1};
    v[4] = '{1'b0, 4'd10, 32'd3,         32'd4,         32'd0,         1'b1};
    v[5] = '{1'b1, 4'd15, 32'd3,         32'd4,         32'd0,         1'b1};
    v[6] = '{1'b1, SLL,   32'd1,         32'd31,        32'h8000_0000, 1'b0};
    v[7] = '{1'b0, SUB,   32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0};
    for (int unsigned i = 0; i < 8; i++) begin
      logic [1:0] sel;
      sel = v[i].id ? 2'b10 : 2'b01;
      if (v[i].id) begin req_op_1 = v[i].op; req_a_1 = v[i].a; req_b_1 = v[i].b; end
      else         begin req_op_0 = v[i].op; req_a_0 = v[i].a; req_b_0 = v[i].b; end
      req_valid = sel;
      #1;
      total++;
      if (req_ready !== sel) begin bad++; $display("FAIL op%0d_ready: got %b want %b", i, req_ready, sel); end
      tick();
      req_valid = 2'b00;
      total++;
      if (alu_operation !== v[i].op) begin
        bad++; $display("FAIL op%0d_aluop: got %h want %h", i, alu_operation, v[i].op);
      end
      tick();
      total++;
      if (resp_valid !== sel || resp_data !== v[i].exp || resp_err !== v[i].err) begin
        bad++; $display("FAIL op%0d_resp: got v=%b d=%h e=%b want %b/%h/%b",
                        i, resp_valid, resp_data, resp_err, sel, v[i].exp, v[i].err);
      end
      resp_ready = sel;
      tick();
      resp_ready = 2'b00;
    end
  endtask

  task automatic test_stall();
    req_valid = 2'b01; req_op_0 = OR; req_a_0 = 32'h0F00; req_b_0 = 32'h00F0;
    resp_ready = 2'b00;
    tick();
    req_valid = 2'b00;
    tick();
    for (int unsigned i = 0; i < 5; i++) begin
      total++;
      if (resp_valid !== 2'b01 || resp_data !== 32'h0FF0 || req_ready !== 2'b00 || alu_in_1 !== 32'h0F00) begin
        bad++; $display("FAIL stall%0d: got v=%b d=%h rdy=%b a=%h want 01/ff0/00/f00",
                        i, resp_valid, resp_data, req_ready, alu_in_1);
      end
      req_a_0 = 32'(i) + 32'h100; req_a_1 = 32'(i); req_valid = 2'b11; resp_ready = 2'b10;
      tick();
    end
    req_valid = 2'b00; resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    total++;
    if (resp_valid !== 2'b00) begin bad++; $display("FAIL stall_release: got %b want 00", resp_valid); end
  endtask

  task automatic test_reset_exec();
    req_valid = 2'b01; req_op_0 = ADD; req_a_0 = 32'd1; req_b_0 = 32'd2;
    tick();
    reset = 1'b1; req_valid = 2'b01;
    #1;
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_exec_ready: got %b want 00", req_ready); end
    tick();
    total++;
    if (resp_valid !== 2'b00 || resp_data !== 32'd0 || resp_err !== 1'b0 ||
        alu_in_1 !== 32'd0 || alu_in_2 !== 32'd0 || alu_operation !== 4'd0) begin
      bad++; $display("FAIL rst_exec_vals: got v=%b d=%h e=%b a=%h b=%h op=%h want all 0",
                      resp_valid, resp_data, resp_err, alu_in_1, alu_in_2, alu_operation);
    end
    reset = 1'b0; req_valid = 2'b00; resp_ready = 2'b11;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      total++;
      if (resp_valid !== 2'b00) begin bad++; $display("FAIL rst_stale%0d: got %b want 00", i, resp_valid); end
    end
    resp_ready = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    int          acc_cyc[$];
    int unsigned k;
    int          nresp;
    logic        pending;
    k = 0; nresp = 0; pending = 1'b0;
    req_valid = 2'b01; req_op_0 = ADD; req_a_0 = 32'd0; req_b_0 = 32'd100; resp_ready = 2'b01;
    #1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (resp_valid == 2'b01) begin
        nresp++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra: got d=%h want no response", resp_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (resp_data !== e) begin bad++; $display("FAIL b2b_data: got %h want %h", resp_data, e); end
        end
      end
      if (req_ready[0]) begin
        acc_cyc.push_back(cyc);
        exp_q.push_back(32'd100 + k);
        pending = 1'b1;
      end
      tick();
      if (pending) begin k++; req_a_0 = k; pending = 1'b0; end
    end
    req_valid = 2'b00;
    total++;
    if (acc_cyc.size() != 5 || nresp != 5) begin
      bad++; $display("FAIL b2b_count: got acc=%0d resp=%0d want 5/5", acc_cyc.size(), nresp);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      total++;
      if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
        bad++; $display("FAIL b2b_gap%0d: got %0d want 3", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    tick();
    resp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_add();
    test_contention();
    test_opcodes();
    test_stall();
    test_reset_exec();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
